// File: rtl/alu_64_pkg.sv
// Shared types and opcode constants for the 64-bit Y86-64 execute-stage ALU.
package alu_64_pkg;

    typedef logic signed [63:0] word_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    function automatic logic is_zero(input word_t v);
        return ~(|v);
    endfunction

endpackage

// File: rtl/alu_64_if.sv
// Operand/opcode request and registered result/flags of the ALU, grouped as one bus.
interface alu_64_if;
    import alu_64_pkg::*;

    logic [1:0] opcode;
    word_t      a;
    word_t      b;
    word_t      res;
    logic       overflow;
    logic       zero;

    modport master (
        output opcode, a, b,
        input  res, overflow, zero
    );

    modport slave (
        input  opcode, a, b,
        output res, overflow, zero
    );

endinterface

// File: rtl/alu_64_addsub.sv
// Shared 64-bit adder: subtraction is a + ~b + 1 on the same carry chain.
module alu_64_addsub
    import alu_64_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  sub,
    output word_t sum,
    output logic  cout,
    output logic  ovf
);

    logic [63:0] b_eff_s;
    logic [64:0] full_s;

    // Operand conditioning, carry chain and signed-overflow detection
    always_comb begin
        b_eff_s = '0;
        full_s  = '0;
        if (sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        full_s = {1'b0, a} + {1'b0, b_eff_s} + {64'd0, sub};
        sum    = full_s[63:0];
        cout   = full_s[64];
        // Overflow when both effective addends share a sign that the sum does not
        ovf    = (a[63] == b_eff_s[63]) && (full_s[63] != a[63]);
    end

endmodule

// File: rtl/alu_64.sv
// 64-bit ALU (ADD/SUB/AND/XOR) with registered result, overflow and zero flags.
module alu_64
    import alu_64_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    alu_64_if.slave  bus
);

    word_t sum_s;
    logic  as_ovf_s;
    logic  unused_carry_s;
    logic  sub_s;
    word_t and_s;
    word_t xor_s;
    word_t res_s;
    logic  ovf_s;
    logic  zero_s;

    word_t res_r;
    logic  ovf_r;
    logic  zero_r;

    assign sub_s = (bus.opcode == ALU_SUB);

    alu_64_addsub u_addsub (
        .a   (bus.a),
        .b   (bus.b),
        .sub (sub_s),
        .sum (sum_s),
        .cout(unused_carry_s),
        .ovf (as_ovf_s)
    );

    // Logic ops, result select and zero detect for the next register state
    always_comb begin
        and_s  = bus.a & bus.b;
        xor_s  = bus.a ^ bus.b;
        res_s  = 64'sd0;
        ovf_s  = 1'b0;
        case (bus.opcode)
            ALU_ADD: begin
                res_s = sum_s;
                ovf_s = as_ovf_s;
            end
            ALU_SUB: begin
                res_s = sum_s;
                ovf_s = as_ovf_s;
            end
            ALU_AND: begin
                res_s = and_s;
                ovf_s = 1'b0;
            end
            ALU_XOR: begin
                res_s = xor_s;
                ovf_s = 1'b0;
            end
            default: begin
                res_s = 64'sd0;
                ovf_s = 1'b0;
            end
        endcase
        zero_s = is_zero(res_s);
    end

    // Output register stage; reset value reports a zero result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r  <= 64'sd0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b1;
        end else begin
            res_r  <= res_s;
            ovf_r  <= ovf_s;
            zero_r <= zero_s;
        end
    end

    assign bus.res      = res_r;
    assign bus.overflow = ovf_r;
    assign bus.zero     = zero_r;

endmodule

// File: tb/tb_alu_64.sv
// Scoreboard bench for alu_64: stimulus pushes expected results, a monitor pops and compares.
module tb_alu_64;
    import alu_64_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic        zero;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_chk;
    int   n_fail;

    alu_64_if bus ();

    alu_64 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, " res"}, bus.res, 64'h0);
        check({name, " overflow"}, {63'd0, bus.overflow}, 64'd0);
        check({name, " zero"}, {63'd0, bus.zero}, 64'd1);
    endtask

    // Drive one operation and queue its hand-supplied expected outcome
    task automatic set_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic eo, input string tag);
        exp_t e;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        e.res  = er;
        e.ovf  = eo;
        e.zero = (er == 64'h0);
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic eo, input string tag);
        @(negedge clk);
        set_op(op, a, b, er, eo, tag);
    endtask

    // Golden model: overflow from a 65-bit sign-extended result
    task automatic model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic o);
        logic [64:0] w;
        w = 65'd0;
        r = 64'h0;
        o = 1'b0;
        case (op)
            2'b00: begin
                w = {a[63], a} + {b[63], b};
                r = w[63:0];
                o = (w[64] != w[63]);
            end
            2'b01: begin
                w = {a[63], a} - {b[63], b};
                r = w[63:0];
                o = (w[64] != w[63]);
            end
            2'b10: r = a & b;
            default: r = a ^ b;
        endcase
    endtask

    // Monitor: one result per clock while out of reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, " res"}, bus.res, e.res);
                check({e.tag, " overflow"}, {63'd0, bus.overflow}, {63'd0, e.ovf});
                check({e.tag, " zero"}, {63'd0, bus.zero}, {63'd0, e.zero});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] er;
        logic        eo;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.opcode = 2'b00;
        bus.a      = 64'h1234_5678_9ABC_DEF0;
        bus.b      = 64'h0FED_CBA9_8765_4321;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset("reset hold");
            bus.a = {$urandom, $urandom};
        end

        @(negedge clk);
        rst_n = 1'b1;
        set_op(ALU_ADD, 64'd11, 64'd42, 64'd53, 1'b0, "add 11+42");
        issue(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, "add pos ovf");
        issue(ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, "add neg ovf");
        issue(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0, "add -1+1");
        issue(ALU_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub 5-7");
        issue(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "sub min-1");
        issue(ALU_SUB, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "sub 0-min");
        issue(ALU_SUB, 64'd42, 64'd42, 64'h0, 1'b0, "sub 42-42");
        issue(ALU_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, "and");
        issue(ALU_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, "xor");
        issue(ALU_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0, 1'b0, "xor a=b");
        issue(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "add mixed sign");

        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 8 == 0) begin
                ra[63:60] = 4'h7;
                rb[63:60] = 4'h7;
            end else if (i % 8 == 1) begin
                ra[63:60] = 4'h8;
                rb[63:60] = 4'h7;
            end
            model(op, ra, rb, er, eo);
            issue(op, ra, rb, er, eo, "random");
        end

        issue(ALU_ADD, 64'd100, 64'd23, 64'd123, 1'b0, "pre-reset add");
        @(negedge clk);
        bus.opcode = ALU_SUB;
        bus.a      = 64'd1;
        bus.b      = 64'd2;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async reset");
        @(posedge clk);
        #1;
        check_reset("reset mid-stream");
        @(negedge clk);
        rst_n = 1'b1;
        set_op(ALU_XOR, 64'h55, 64'h0F, 64'h5A, 1'b0, "post-reset xor");
        issue(ALU_SUB, 64'd10, 64'd3, 64'd7, 1'b0, "post-reset sub");

        repeat (4) @(posedge clk);
        #2;
        check("scoreboard drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
